// File: rtl/cpu_mailbox_pkg.sv
// cpu_mailbox_pkg: register map offsets and STATUS/IRQ_EN bit positions for the CPU mailbox
package cpu_mailbox_pkg;
  localparam logic [2:0] REG_STATUS  = 3'd0;
  localparam logic [2:0] REG_RX_DATA = 3'd1;
  localparam logic [2:0] REG_RX_POP  = 3'd2;
  localparam logic [2:0] REG_TX_DATA = 3'd3;
  localparam logic [2:0] REG_IRQ_EN  = 3'd4;
  localparam int ST_RX_NONEMPTY = 0;
  localparam int ST_TX_FULL     = 1;
  localparam int ST_TX_OVF      = 2;
  localparam int IE_RX          = 0;
  localparam int IE_TX          = 1;
endpackage

// File: rtl/cpu_mailbox_fifo.sv
// mailbox_fifo: synchronous FIFO with combinational head; a pop on a full FIFO frees room for a same-cycle push
module mailbox_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head = mem[rp];
  always_ff @(posedge clock) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clock)
    if (do_push) mem[wp] <= wdata;
endmodule

// File: rtl/cpu_mailbox.sv
// cpu_mailbox: memory-mapped RX/TX packet mailbox with registered read data and level interrupt
module cpu_mailbox
  import cpu_mailbox_pkg::*;
#(
  parameter int MEMORY_BUS_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter logic [MEMORY_BUS_WIDTH-3:0] BASE_ADDR = '0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [MEMORY_BUS_WIDTH-3:0] addr_out,
  input  logic [MEMORY_BUS_WIDTH-1:0] data_out,
  input  logic [3:0]                  wb_out,
  output logic [MEMORY_BUS_WIDTH-1:0] data_in,
  output logic                        irq,
  input  logic                        rx_valid,
  input  logic [MEMORY_BUS_WIDTH-1:0] rx_data,
  output logic                        rx_ready,
  output logic                        tx_valid,
  output logic [MEMORY_BUS_WIDTH-1:0] tx_data,
  input  logic                        tx_ready
);
  localparam int W = MEMORY_BUS_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic hit, wr;
  logic [2:0] off;
  logic rx_full, rx_empty, tx_full, tx_empty;
  logic [CW-1:0] rx_count, tx_count;
  logic [W-1:0] rx_head, status, rdata;
  logic rx_push, rx_pop, tx_push, tx_pop, tx_drop;
  logic [1:0] irq_en;
  logic tx_overflow;
  assign off = addr_out[2:0];
  assign hit = addr_out[W-3:3] == BASE_ADDR[W-3:3];
  assign wr = hit && wb_out != 4'h0;
  assign rx_push = rx_valid & ~rx_full;
  assign rx_pop = wr && off == REG_RX_POP;
  assign tx_push = wr && off == REG_TX_DATA && wb_out == 4'hF;
  assign tx_pop = tx_ready & ~tx_empty;
  // rx_ready deliberately ignores a same-cycle RX_POP so the network side sees no combinational path
  assign tx_drop = tx_push & tx_full & ~tx_pop;
  assign rx_ready = ~rx_full;
  assign tx_valid = ~tx_empty;
  mailbox_fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) rx_fifo (
    .clock(clock), .reset(reset), .push(rx_push), .pop(rx_pop), .wdata(rx_data),
    .full(rx_full), .empty(rx_empty), .count(rx_count), .head(rx_head)
  );
  mailbox_fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) tx_fifo (
    .clock(clock), .reset(reset), .push(tx_push), .pop(tx_pop), .wdata(data_out),
    .full(tx_full), .empty(tx_empty), .count(tx_count), .head(tx_data)
  );
  always_comb begin
    status = '0;
    status[ST_RX_NONEMPTY] = ~rx_empty;
    status[ST_TX_FULL] = tx_full;
    status[ST_TX_OVF] = tx_overflow;
    status[15:8] = 8'(rx_count);
    status[23:16] = 8'(tx_count);
    rdata = !hit ? '0 :
            off == REG_STATUS ? status :
            off == REG_RX_DATA ? (rx_empty ? '0 : rx_head) :
            off == REG_IRQ_EN ? W'(irq_en) : '0;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      irq_en <= '0;
      tx_overflow <= 1'b0;
      data_in <= '0;
      irq <= 1'b0;
    end else begin
      data_in <= rdata;
      irq <= (irq_en[IE_RX] & ~rx_empty) | (irq_en[IE_TX] & tx_empty);
      if (wr && off == REG_IRQ_EN) irq_en <= data_out[1:0];
      if (tx_drop) tx_overflow <= 1'b1;
      else if (wr && off == REG_STATUS && data_out[ST_TX_OVF]) tx_overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cpu_mailbox.sv
// tb_cpu_mailbox: randomized and directed stimulus against a queue-based mailbox model
module tb_cpu_mailbox;
  localparam int D = 8;
  localparam logic [29:0] BASE = 30'h40;
  logic clock = 0, reset = 1;
  logic [29:0] addr = BASE;
  logic [31:0] dout = 0, rxd = 0, data_in, tx_data;
  logic [3:0] wb = 0;
  logic rxv = 0, txr = 0, irq, rx_ready, tx_valid;
  int checks = 0, errors = 0;
  bit chk_en = 0;
  logic [31:0] rxq[$], txq[$];
  logic m_ovf = 0, exp_irq = 0, din_chk = 0;
  logic [1:0] m_ien = 0;
  logic [31:0] exp_din = 0, r;
  cpu_mailbox #(.MEMORY_BUS_WIDTH(32), .FIFO_DEPTH(D), .BASE_ADDR(BASE)) dut (
    .clock(clock), .reset(reset), .addr_out(addr), .data_out(dout), .wb_out(wb),
    .data_in(data_in), .irq(irq), .rx_valid(rxv), .rx_data(rxd), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(txr)
  );
  always #5 clock = ~clock;
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask
  // Model: applies the register-map and FIFO rules to queues once per rising edge
  always @(posedge clock) begin
    logic h, w, rx_pop, rx_push, tx_pop, tx_req, tx_ok;
    logic [2:0] o;
    if (reset) begin
      rxq.delete(); txq.delete();
      m_ovf = 0; m_ien = 0; exp_din = 0; exp_irq = 0; din_chk = 1;
    end else begin
      h = addr[29:3] == BASE[29:3];
      o = addr[2:0];
      w = h && wb != 0;
      exp_irq = (m_ien[0] && rxq.size() > 0) || (m_ien[1] && txq.size() == 0);
      din_chk = wb == 0;
      exp_din = 0;
      if (h && o == 0) exp_din = {8'd0, 8'(txq.size()), 8'(rxq.size()), 5'd0, m_ovf, txq.size() == D, rxq.size() > 0};
      if (h && o == 1 && rxq.size() > 0) exp_din = rxq[0];
      if (h && o == 4) exp_din = {30'd0, m_ien};
      rx_pop = w && o == 2 && rxq.size() > 0;
      rx_push = rxv && rxq.size() < D;
      tx_pop = txr && txq.size() > 0;
      tx_req = w && o == 3 && wb == 4'hF;
      tx_ok = tx_req && (txq.size() < D || tx_pop);
      if (rx_pop) void'(rxq.pop_front());
      if (rx_push) rxq.push_back(rxd);
      if (tx_pop) void'(txq.pop_front());
      if (tx_ok) txq.push_back(dout);
      if (w && o == 0 && dout[2]) m_ovf = 0;
      if (tx_req && !tx_ok) m_ovf = 1;
      if (w && o == 4) m_ien = dout[1:0];
    end
  end
  always @(negedge clock) if (chk_en) begin
    cmp("rx_ready", 32'(rx_ready), 32'(rxq.size() < D));
    cmp("tx_valid", 32'(tx_valid), 32'(txq.size() > 0));
    if (txq.size() > 0) cmp("tx_data", tx_data, txq[0]);
    cmp("irq", 32'(irq), 32'(exp_irq));
    if (din_chk) cmp("data_in", data_in, exp_din);
  end
  task automatic step(); @(posedge clock); #1; endtask
  task automatic wr(input logic [29:0] a, input logic [31:0] d, input logic [3:0] be);
    addr = a; dout = d; wb = be; step(); wb = 0;
  endtask
  task automatic rd(input logic [29:0] a, output logic [31:0] d);
    addr = a; wb = 0; step(); d = data_in;
  endtask
  task automatic rx_push(input logic [31:0] d);
    rxv = 1; rxd = d; step(); rxv = 0;
  endtask
  initial begin
    step(); step();
    reset = 0;
    chk_en = 1;
    rd(BASE + 0, r); cmp("reset_status", r, 32'h0);
    cmp("reset_irq", 32'(irq), 0); cmp("reset_rx_ready", 32'(rx_ready), 1); cmp("reset_tx_valid", 32'(tx_valid), 0);
    rx_push(32'hA5A5_0001); rx_push(32'hA5A5_0002);
    wr(BASE + 4, 32'h1, 4'hF);
    rd(BASE + 0, r); cmp("status_2rx", r, 32'h0000_0201);
    cmp("irq_rx", 32'(irq), 1);
    rd(BASE + 1, r); cmp("rx_head1", r, 32'hA5A5_0001);
    wr(BASE + 2, 32'h0, 4'hF);
    rd(BASE + 1, r); cmp("rx_head2", r, 32'hA5A5_0002);
    wr(BASE + 2, 32'h0, 4'h1);
    rd(BASE + 0, r); cmp("status_rx_empty", r, 32'h0);
    cmp("irq_cleared", 32'(irq), 0);
    for (int i = 0; i < 9; i++) wr(BASE + 3, 32'h100 + i, 4'hF);
    rd(BASE + 0, r); cmp("status_tx_full_ovf", r, 32'h0008_0006);
    wr(BASE + 0, 32'h4, 4'hF);
    rd(BASE + 0, r); cmp("status_w1c", r, 32'h0008_0002);
    txr = 1;
    for (int i = 0; i < 8; i++) begin cmp("tx_drain", tx_data, 32'h100 + i); step(); end
    txr = 0;
    cmp("tx_drained", 32'(tx_valid), 0);
    wr(BASE + 3, 32'hDEAD, 4'h3);
    rd(BASE + 0, r); cmp("partial_tx_ignored", r, 32'h0);
    cmp("partial_tx_valid", 32'(tx_valid), 0);
    for (int i = 0; i < 8; i++) rx_push(32'h200 + i);
    cmp("rx_full_ready", 32'(rx_ready), 0);
    addr = BASE + 2; wb = 4'hF; rxv = 1; rxd = 32'hBAD; step(); wb = 0; rxv = 0;
    cmp("rx_ready_after_pop", 32'(rx_ready), 1);
    rd(BASE + 0, r); cmp("status_pop_only", r, 32'h0000_0701);
    rd(BASE + 1, r); cmp("rx_head_after_pop", r, 32'h201);
    wr(BASE + 8 + 2, 32'hFFFF_FFFF, 4'hF);
    wr(BASE + 8 + 3, 32'h1234, 4'hF);
    for (int o = 5; o < 8; o++) begin rd(BASE + 30'(o), r); cmp("reserved_rd", r, 32'h0); end
    rd(BASE + 8, r); cmp("miss_rd", r, 32'h0);
    rd(BASE + 0, r); cmp("status_after_miss", r, 32'h0000_0701);
    for (int i = 0; i < 4; i++) wr(BASE + 2, 32'h0, 4'hF);
    for (int i = 0; i < 3; i++) wr(BASE + 3, 32'h300 + i, 4'hF);
    rd(BASE + 0, r); cmp("status_3_3", r, 32'h0003_0301);
    cmp("irq_before_reset", 32'(irq), 1);
    reset = 1; step(); reset = 0;
    cmp("irq_after_reset", 32'(irq), 0);
    rd(BASE + 0, r); cmp("status_after_reset", r, 32'h0);
    cmp("tx_valid_after_reset", 32'(tx_valid), 0);
    for (int i = 0; i < 4000; i++) begin
      logic [3:0] bes [5];
      bes = '{4'h0, 4'h0, 4'hF, 4'h3, 4'h1};
      addr = ($urandom_range(0, 7) == 0) ? BASE + 8 + 30'($urandom_range(0, 7)) : BASE + 30'($urandom_range(0, 7));
      wb = bes[$urandom_range(0, 4)];
      dout = $urandom;
      rxv = $urandom_range(0, 1) == 1;
      rxd = $urandom;
      txr = $urandom_range(0, 2) == 0;
      reset = $urandom_range(0, 299) == 0;
      step();
    end
    wb = 0; rxv = 0; txr = 0; reset = 0;
    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
